ysyx_23060042_ifu: RTL and testbench
====================================

# ysyx_23060042_IFU

Instruction fetch unit for the NPC core. It sits upstream of the decoder and owns the fetch PC. It issues one-outstanding word reads to instruction memory and queues returned instructions with their PCs in a small FIFO. It presents them to the decoder through a valid/ready handshake. Control-flow redirects from execute (jump/branch targets) flush the queue and kill any in-flight fetch.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: first fetch address after reset.
- `DEPTH`, default `2`: instruction FIFO entries; must be a power of 2 and ≥2.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `redirect_valid` in 1: redirect the fetch stream this cycle.
- `redirect_pc` in 32: redirect target.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: word address (byte-addressed, `[1:0]=00`).
- `imem_rsp_valid` in 1: read data valid; at most one per accepted request; never in the same cycle as acceptance.
- `imem_rsp_data` in 32: instruction word.
- `inst_valid` out 1: FIFO head valid toward the decoder.
- `inst_ready` in 1: decoder consumes the head.
- `inst` out 32: head instruction.
- `inst_pc` out 32: PC of the head instruction.
- `misalign` out 1: sticky misaligned-redirect flag; tied 0 without the macro.

## Operation
- **State register**: `fetch_pc` (reset `RESET_PC`).
- **FSM states**:
  - `REQ`: drive `imem_req_valid`, with `imem_req_addr = fetch_pc`.
  - `WAIT`: one request outstanding.
  - `DROP`: the outstanding request was killed; its response is swallowed.
- **Issue gating**: `REQ` asserts `imem_req_valid` only when `fifo_count + outstanding < DEPTH`. Otherwise it holds with valid low.
- **Request handshake** (`REQ` with valid && ready): `fetch_pc += 4` (wraps modulo 2^32), go to `WAIT`.
- **`WAIT` response**: on `imem_rsp_valid`, push `{pc, imem_rsp_data}` into the FIFO, then go to `REQ`.
- **`DROP` response**: on `imem_rsp_valid`, discard the data and go to `REQ`.
- **Redirect**: `redirect_valid` has priority over everything else in the same cycle.
  - The FIFO flushes and `fetch_pc <= redirect_pc`.
  - From `WAIT`: go to `DROP`. If a response arrives in the same cycle, it is discarded and the state goes to `REQ`.
  - From `REQ` with a handshake in the same cycle: go to `DROP`.
  - From `REQ` without a handshake: stay in `REQ` and present the new address next cycle. The imem port permits the address to change before acceptance.
  - From `DROP`: stay in `DROP`, or go to `REQ` if the response arrives in that cycle.
- **FIFO**:
  - Push and pop may occur in the same cycle, including when full.
  - A pop on empty is ignored.
  - Flush overrides a simultaneous push and pop.
- **Reset values**: all outputs 0, `fetch_pc = RESET_PC`, state `REQ`, FIFO empty. An asynchronous reset mid-`WAIT` abandons the request; imem is reset by the same `rst_n`.

## Timing
- `imem_req_valid` can rise in the first cycle after `rst_n` deasserts.
- Minimum latency:
  - Request accepted at cycle N.
  - Response at N+1.
  - `inst_valid` at N+2.
  - There is no combinational bypass from `imem_rsp` to `inst`.
- Peak throughput is one instruction per 2 cycles (`REQ` → `WAIT` → `REQ`).
- `inst`/`inst_pc` are registered FIFO outputs and stay stable while `inst_valid && !inst_ready`.
- A redirect at cycle R drops `inst_valid` at R+1. The earliest request to `redirect_pc` is at R+1.

## Configuration
- **`YSYX_23060042_IFU_ALIGN_CHECK_EN` defined**:
  - A redirect with `redirect_pc[1:0] != 0` sets `misalign` at the next edge; it is sticky until reset.
  - The FIFO flushes, and `imem_req_valid` stays 0 thereafter.
- **Undefined**: `redirect_pc[1:0]` is ignored (forced to 00) and `misalign` is constant 0.

## Structure
- **Package `ysyx_23060042_pkg`** holds:
  - `ifu_state_t` (enum `REQ`/`WAIT`/`DROP`).
  - `ifu_entry_t` (packed struct `{pc[31:0], inst[31:0]}`).
  - `DEFAULT_RESET_PC` constant.
- **Sub-module `ysyx_23060042_ifu_fifo`**: parameterised synchronous FIFO of `ifu_entry_t` with push/pop/flush ports, count output, and the same `clk`/`rst_n`.

## Test plan
- **Basic fetch**: release reset with `imem_req_ready=1`, 1-cycle response `0x00000013`, `inst_ready=1` → request addresses 0x80000000, 0x80000004, …; first `inst_valid` 2 cycles after acceptance with `inst_pc=0x80000000`, `inst=0x00000013`.
- **Backpressure**: `inst_ready=0` → after 2 entries queued, `imem_req_valid` stays 0. Raise `inst_ready` → heads pop in order, and the next request is 0x80000008.
- **Redirect in `WAIT`**: redirect to 0x80001000 while `WAIT`, response arrives next cycle → response discarded, `inst_valid=0`, next request address 0x80001000.
- **Simultaneous redirect and response**: `redirect_valid` in the same cycle as `imem_rsp_valid` → no FIFO push; next request is `redirect_pc`.
- **Reset mid-fetch**: assert `rst_n=0` in `WAIT` → all outputs 0 asynchronously; after release, the first request is 0x80000000.
- **Alignment check** (macro on): redirect to 0x80000002 → `misalign=1` next cycle, `imem_req_valid` stays 0, `inst_valid=0` until reset.

Source files
------------

// File: rtl/ysyx_23060042_pkg.sv
// Shared types and constants for the NPC instruction fetch unit.
// Imported by the IFU top and its instruction FIFO.
package ysyx_23060042_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } ifu_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifu_entry_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060042_ifu_fifo.sv
// Instruction FIFO: queues {pc, inst} entries between fetch and decode.
// Storage is flops, so the head is a registered output.
module ysyx_23060042_ifu_fifo
    import ysyx_23060042_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  ifu_entry_t               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output ifu_entry_t               head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ifu_entry_t      mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_pop;
    logic            do_push;

    assign do_pop     = pop && (count != '0);
    assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);
    assign head       = mem[rd_ptr];
    assign head_valid = (count != '0);

    // Pointer, count and storage update; flush beats push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ysyx_23060042_ifu.sv
// NPC instruction fetch unit: one-outstanding imem reads into a FIFO.
// Optional macro YSYX_23060042_IFU_ALIGN_CHECK_EN enables misalign trap.
module ysyx_23060042_ifu
    import ysyx_23060042_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        misalign
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifu_state_t   state;
    ifu_state_t   state_nxt;
    logic [31:0]  fetch_pc;
    logic [31:0]  target;
    logic         live;
    logic         fire;
    logic         push;
    logic         outstanding;
    logic         room;
    logic [CW-1:0] count;
    ifu_entry_t   head;
    ifu_entry_t   push_data;

`ifdef YSYX_23060042_IFU_ALIGN_CHECK_EN
    logic misalign_q;

    assign target   = redirect_pc;
    assign misalign = misalign_q;

    // A misaligned redirect latches the trap until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end
`else
    assign target   = redirect_pc & ~32'h3;
    assign misalign = 1'b0;
`endif

    assign outstanding   = (state != REQ);
    assign room          = (count + CW'(outstanding)) < CW'(DEPTH);
    assign fire          = imem_req_valid && imem_req_ready;
    assign imem_req_addr = imem_req_valid ? fetch_pc : 32'h0;

    // fetch_pc already advanced past the outstanding request.
    assign push_data.pc   = fetch_pc - 32'd4;
    assign push_data.inst = imem_rsp_data;

    // Holds requests off until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a redirect turns any live request into a dropped one.
    always_comb begin
        state_nxt = state;
        unique case (state)
            REQ: begin
                if (fire) begin
                    state_nxt = redirect_valid ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = REQ;
                end else if (redirect_valid) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = REQ;
        endcase
    end

    // FSM outputs: request issue and FIFO push.
    always_comb begin
        imem_req_valid = 1'b0;
        push           = 1'b0;
        unique case (state)
            REQ:     imem_req_valid = live && room && !misalign;
            WAIT:    push = imem_rsp_valid && !redirect_valid;
            default: ;
        endcase
    end

    // Fetch PC: redirect wins over sequential advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= target;
        end else if (fire) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    ysyx_23060042_ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_data),
        .pop        (inst_ready),
        .flush      (redirect_valid),
        .head       (head),
        .head_valid (inst_valid),
        .count      (count)
    );

    assign inst    = head.inst;
    assign inst_pc = head.pc;

endmodule

// File: tb/tb_ysyx_23060042_ifu.sv
// Directed testbench for ysyx_23060042_ifu with a small imem responder.
// Responses return data = addr ^ 32'h8000_0013 after a settable latency.
module tb_ysyx_23060042_ifu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misalign;

    int checks = 0;
    int errors = 0;
    int lat = 1;

    logic        pend;
    int          cnt;
    logic [31:0] paddr;

    localparam logic [31:0] K = 32'h8000_0013;

    ysyx_23060042_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    // Instruction memory model: one response per accepted request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend           <= 1'b0;
            cnt            <= 0;
            paddr          <= 32'h0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (pend) begin
                if (cnt == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= paddr ^ K;
                    pend           <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                if (lat == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= imem_req_addr ^ K;
                end else begin
                    pend  <= 1'b1;
                    cnt   <= lat - 1;
                    paddr <= imem_req_addr;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Returns at the negedge of the first cycle after reset release.
    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        tick();
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'h0);

        // Basic fetch, 1-cycle memory, decoder always ready
        rst_n = 1'b1;
        tick();
        check("bf_c1_valid", {31'b0, imem_req_valid}, 32'h1);
        check("bf_c1_addr", imem_req_addr, 32'h8000_0000);
        check("bf_c1_ivalid", {31'b0, inst_valid}, 32'h0);
        tick();
        check("bf_c2_wait", {31'b0, imem_req_valid}, 32'h0);
        tick();
        check("bf_c3_ivalid", {31'b0, inst_valid}, 32'h1);
        check("bf_c3_inst", inst, 32'h0000_0013);
        check("bf_c3_pc", inst_pc, 32'h8000_0000);
        check("bf_c3_addr", imem_req_addr, 32'h8000_0004);
        tick();
        check("bf_c4_ivalid", {31'b0, inst_valid}, 32'h0);
        tick();
        check("bf_c5_inst", inst, 32'h0000_0017);
        check("bf_c5_pc", inst_pc, 32'h8000_0004);
        check("bf_c5_addr", imem_req_addr, 32'h8000_0008);

        // Backpressure: two entries fill the FIFO, issue stalls
        inst_ready = 1'b0;
        lat = 1;
        do_reset();
        repeat (4) tick();
        check("bp_c5_stall", {31'b0, imem_req_valid}, 32'h0);
        check("bp_c5_pc", inst_pc, 32'h8000_0000);
        tick();
        check("bp_c6_stall", {31'b0, imem_req_valid}, 32'h0);
        check("bp_c6_inst", inst, 32'h0000_0013);
        inst_ready = 1'b1;
        tick();
        check("bp_c7_pc", inst_pc, 32'h8000_0004);
        check("bp_c7_inst", inst, 32'h0000_0017);
        check("bp_c7_valid", {31'b0, imem_req_valid}, 32'h1);
        check("bp_c7_addr", imem_req_addr, 32'h8000_0008);

        // Redirect in WAIT, response one cycle later is dropped
        lat = 2;
        do_reset();
        tick();
        check("rw_c2_wait", {31'b0, imem_req_valid}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1000;
        tick();
        redirect_valid = 1'b0;
        check("rw_c3_rsp", {31'b0, imem_rsp_valid}, 32'h1);
        check("rw_c3_drop", {31'b0, imem_req_valid}, 32'h0);
        check("rw_c3_ivalid", {31'b0, inst_valid}, 32'h0);
        tick();
        check("rw_c4_ivalid", {31'b0, inst_valid}, 32'h0);
        check("rw_c4_valid", {31'b0, imem_req_valid}, 32'h1);
        check("rw_c4_addr", imem_req_addr, 32'h8000_1000);
        repeat (3) tick();
        check("rw_c7_ivalid", {31'b0, inst_valid}, 32'h1);
        check("rw_c7_pc", inst_pc, 32'h8000_1000);
        check("rw_c7_inst", inst, 32'h0000_1013);

        // Redirect in the same cycle as the response
        lat = 1;
        do_reset();
        tick();
        check("sr_c2_rsp", {31'b0, imem_rsp_valid}, 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_2000;
        tick();
        redirect_valid = 1'b0;
        check("sr_c3_ivalid", {31'b0, inst_valid}, 32'h0);
        check("sr_c3_valid", {31'b0, imem_req_valid}, 32'h1);
        check("sr_c3_addr", imem_req_addr, 32'h8000_2000);

        // Redirect in REQ without handshake retargets the request
        imem_req_ready = 1'b0;
        do_reset();
        check("rq_c1_addr", imem_req_addr, 32'h8000_0000);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_4000;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        check("rq_c2_valid", {31'b0, imem_req_valid}, 32'h1);
        check("rq_c2_addr", imem_req_addr, 32'h8000_4000);

        // Asynchronous reset while a request is outstanding
        inst_ready = 1'b0;
        lat = 1;
        do_reset();
        repeat (3) tick();
        check("rm_c4_ivalid", {31'b0, inst_valid}, 32'h1);
        check("rm_c4_rsp", {31'b0, imem_rsp_valid}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rm_async_ivalid", {31'b0, inst_valid}, 32'h0);
        check("rm_async_inst", inst, 32'h0);
        check("rm_async_pc", inst_pc, 32'h0);
        check("rm_async_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rm_async_addr", imem_req_addr, 32'h0);
        inst_ready = 1'b1;
        do_reset();
        check("rm_rel_valid", {31'b0, imem_req_valid}, 32'h1);
        check("rm_rel_addr", imem_req_addr, 32'h8000_0000);

        // Misaligned redirect taken together with a handshake in REQ
        lat = 1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_3002;
        tick();
        redirect_valid = 1'b0;
        check("ma_c2_drop", {31'b0, imem_req_valid}, 32'h0);
        check("ma_c2_ivalid", {31'b0, inst_valid}, 32'h0);
`ifdef YSYX_23060042_IFU_ALIGN_CHECK_EN
        check("ma_c2_flag", {31'b0, misalign}, 32'h1);
        tick();
        check("ma_c3_valid", {31'b0, imem_req_valid}, 32'h0);
        check("ma_c3_ivalid", {31'b0, inst_valid}, 32'h0);
        repeat (4) tick();
        check("ma_c7_valid", {31'b0, imem_req_valid}, 32'h0);
        check("ma_c7_flag", {31'b0, misalign}, 32'h1);
`else
        check("ma_c2_flag", {31'b0, misalign}, 32'h0);
        tick();
        check("ma_c3_valid", {31'b0, imem_req_valid}, 32'h1);
        check("ma_c3_addr", imem_req_addr, 32'h8000_3000);
        check("ma_c3_flag", {31'b0, misalign}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
